// File: rtl/sap1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sap1_pkg
//  Description : Shared widths and loader state encoding for the SAP-1
//                program/data memory slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package sap1_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    // Loader state encoding, kept explicit so the register width is fixed
    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_LOAD = 2'd1;
    localparam logic [1:0] C_ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = C_ST_IDLE,
        ST_LOAD = C_ST_LOAD,
        ST_DONE = C_ST_DONE
    } loader_state_t;

    // True when the address is the final word of the array
    function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
        return (addr == {ADDR_W{1'b1}});
    endfunction

endpackage : sap1_pkg
`default_nettype wire

// File: rtl/ram_loader_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : ram_loader_fsm
//  Description : Sequential byte loader for the 16x8 RAM. Accepts one byte
//                per valid/ready beat and walks the write address 0..15.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_loader_fsm
    import sap1_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              prog_mode,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_ready;
    logic              w_beat;

    // A beat only exists while the loader is advertising ready
    assign w_beat = prog_valid & r_ready;

    // Next-state, address counter and done-flag decode
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_done_nxt  = r_done;
        case (r_state)
            ST_IDLE: begin
                if (prog_mode) begin
                    w_state_nxt = ST_LOAD;
                    w_addr_nxt  = '0;
                    w_done_nxt  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (w_beat) begin
                    // Increment wraps 15 -> 0 naturally on the last beat
                    w_addr_nxt = ADDR_W'(r_addr + 1'b1);
                    if (is_last_addr(r_addr)) begin
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
                // Leaving program mode wins over the DONE transition,
                // but a beat in this cycle is still committed
                if (!prog_mode) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (!prog_mode) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and flag registers; ready is registered with the state
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_done  <= w_done_nxt;
            r_ready <= (w_state_nxt == ST_LOAD);
        end
    end

    assign prog_ready = r_ready;
    assign prog_addr  = r_addr;
    assign prog_done  = r_done;
    assign wr_en      = w_beat;
    assign wr_addr    = r_addr;

endmodule : ram_loader_fsm
`default_nettype wire

// File: rtl/ram_16x8.sv
`default_nettype none
// ============================================================================
//  Module      : ram_16x8
//  Description : 16-word x 8-bit program/data memory. Zero-latency read onto
//                the shared W bus in run mode; filled by the sequential
//                loader in program mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_16x8
    import sap1_pkg::*;
#(
    parameter int DATA_W = sap1_pkg::DATA_W,
    parameter int ADDR_W = sap1_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [ADDR_W-1:0] RAM_address,
    input  logic              ce_n,
    inout  wire  [DATA_W-1:0] w_bus,
    input  logic              prog_mode,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_valid,
    output logic              prog_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic              prog_done
);

    localparam int C_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [C_DEPTH];
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_drive;

    ram_loader_fsm u_loader (
        .clk        (clk),
        .clr_n      (clr_n),
        .prog_mode  (prog_mode),
        .prog_valid (prog_valid),
        .prog_ready (prog_ready),
        .prog_addr  (prog_addr),
        .prog_done  (prog_done),
        .wr_en      (w_we),
        .wr_addr    (w_waddr)
    );

    // Loader write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= prog_data;
        end
    end

    // The bus is released throughout program mode so the loader never
    // fights another bus master
    assign w_rd_data = r_mem[RAM_address];
    assign w_drive   = ~ce_n & ~prog_mode;
    assign w_bus     = w_drive ? w_rd_data : {DATA_W{1'bz}};

endmodule : ram_16x8
`default_nettype wire

// File: tb/tb_ram_16x8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_16x8
//  Description : Directed self-checking bench for ram_16x8. The W bus has
//                weak pull-ups, so a released bus reads as 8'hFF.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_16x8;

    logic       clk;
    logic       clr_n;
    logic [3:0] RAM_address;
    logic       ce_n;
    wire  [7:0] w_bus;
    logic       prog_mode;
    logic [7:0] prog_data;
    logic       prog_valid;
    logic       prog_ready;
    logic [3:0] prog_addr;
    logic       prog_done;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [7:0] C_BUS_IDLE = 8'hFF;

    for (genvar b = 0; b < 8; b++) begin : g_pull
        pullup (w_bus[b]);
    end

    ram_16x8 dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .RAM_address (RAM_address),
        .ce_n        (ce_n),
        .w_bus       (w_bus),
        .prog_mode   (prog_mode),
        .prog_data   (prog_data),
        .prog_valid  (prog_valid),
        .prog_ready  (prog_ready),
        .prog_addr   (prog_addr),
        .prog_done   (prog_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic       ce_n;
        logic [7:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab[18];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string name, input logic [3:0] a, input logic [7:0] exp);
        RAM_address = a;
        ce_n        = 1'b0;
        #1;
        check(name, w_bus, exp);
    endtask

    initial begin
        int beats;
        int k;

        for (int i = 0; i < 16; i++) begin
            rd_tab[i].addr = 4'(i);
            rd_tab[i].ce_n = 1'b0;
            rd_tab[i].exp  = 8'(8'h10 + i);
        end
        rd_tab[16].addr = 4'hA; rd_tab[16].ce_n = 1'b1; rd_tab[16].exp = C_BUS_IDLE;
        rd_tab[17].addr = 4'hA; rd_tab[17].ce_n = 1'b0; rd_tab[17].exp = 8'h1A;

        clr_n = 1'b0; RAM_address = '0; ce_n = 1'b1;
        prog_mode = 1'b0; prog_data = '0; prog_valid = 1'b0;
        #12;
        check("rst_ready", {7'd0, prog_ready}, 8'd0);
        check("rst_addr",  {4'd0, prog_addr},  8'd0);
        check("rst_done",  {7'd0, prog_done},  8'd0);
        check("rst_bus",   w_bus, C_BUS_IDLE);
        clr_n = 1'b1;
        step();

        // Full load with valid held high; bus guard with ce_n asserted
        prog_mode = 1'b1; ce_n = 1'b0;
        check("idle_ready", {7'd0, prog_ready}, 8'd0);
        step();
        prog_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_data = 8'(8'h10 + i);
            check("load_ready", {7'd0, prog_ready}, 8'd1);
            check("load_addr",  {4'd0, prog_addr}, 8'(i));
            check("load_done",  {7'd0, prog_done}, 8'd0);
            check("bus_guard",  w_bus, C_BUS_IDLE);
            step();
        end
        check("full_done",  {7'd0, prog_done},  8'd1);
        check("full_ready", {7'd0, prog_ready}, 8'd0);
        check("full_addr",  {4'd0, prog_addr},  8'd0);
        // Bytes offered in DONE must be dropped
        prog_data = 8'hEE;
        step();
        prog_valid = 1'b0;

        // Run-mode reads from the table
        prog_mode = 1'b0;
        step();
        for (int i = 0; i < 18; i++) begin
            RAM_address = rd_tab[i].addr;
            ce_n        = rd_tab[i].ce_n;
            #1;
            check($sformatf("rd_tab[%0d]", i), w_bus, rd_tab[i].exp);
        end
        check("idle_done_kept", {7'd0, prog_done}, 8'd1);

        // Throttled handshake: valid on every third cycle
        ce_n = 1'b1; prog_mode = 1'b1;
        step();
        beats = 0;
        k = 0;
        while (!prog_done && k < 100) begin
            prog_valid = (k % 3 == 0);
            prog_data  = 8'(8'hA0 + beats);
            check("thr_addr", {4'd0, prog_addr}, 8'(beats % 16));
            step();
            if (prog_valid) beats++;
            k++;
        end
        prog_valid = 1'b0;
        check("thr_beats", 8'(beats), 8'd16);
        check("thr_done",  {7'd0, prog_done}, 8'd1);
        prog_mode = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            check_read("thr_rd", 4'(i), 8'(8'hA0 + i));
        end

        // Abort after five bytes, contents retained
        ce_n = 1'b1; prog_mode = 1'b1;
        step();
        check("abt_done_clr", {7'd0, prog_done}, 8'd0);
        check("abt_addr0",    {4'd0, prog_addr}, 8'd0);
        prog_valid = 1'b1; prog_data = 8'h55;
        for (int i = 0; i < 5; i++) step();
        prog_valid = 1'b0; prog_mode = 1'b0;
        step();
        check("abt_ready", {7'd0, prog_ready}, 8'd0);
        check("abt_done",  {7'd0, prog_done},  8'd0);
        for (int i = 0; i < 16; i++) begin
            check_read("abt_rd", 4'(i), (i < 5) ? 8'h55 : 8'(8'hA0 + i));
        end
        ce_n = 1'b1; prog_mode = 1'b1;
        step();
        check("reent_addr",  {4'd0, prog_addr},  8'd0);
        check("reent_ready", {7'd0, prog_ready}, 8'd1);

        // Asynchronous reset between edges after three beats
        prog_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prog_data = 8'(8'hC0 + i);
            step();
        end
        prog_valid = 1'b0;
        check("pre_rst_addr", {4'd0, prog_addr}, 8'd3);
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_ready", {7'd0, prog_ready}, 8'd0);
        check("arst_addr",  {4'd0, prog_addr},  8'd0);
        #1;
        clr_n = 1'b1; prog_mode = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            check_read("arst_rd", 4'(i), 8'(8'hC0 + i));
        end
        check_read("arst_rd3", 4'd3, 8'h55);
        check_read("arst_rd5", 4'd5, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ram_16x8
`default_nettype wire
